omr_sheet_loader: RTL and testbench

- Upstream stage of the OMR grader.
- Accepts answer sheets as a serial stream of one question row per handshake; each row is the OPT_W-bit bubble pattern for that question.
- Assembles the answer-key sheet and student sheets into the flat NUM_Q*OPT_W-bit vectors the grader compares, and classifies each student row as blank or multi-marked.
- Presents the key and student vectors only when they are complete, and holds them stable until the next commit.

---
 rtl/omr_sheet_loader_if.sv | 23 ++
 rtl/omr_sheet_loader.sv | 157 +++++++++++++++
 tb/tb_omr_sheet_loader.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/omr_sheet_loader_if.sv
// rtl/omr_sheet_loader_if.sv - row stream carrying one question's bubble pattern per handshake
interface omr_sheet_loader_if #(
  parameter int OPT_W = 4
);
  logic             row_valid;
  logic             row_ready;
  logic [OPT_W-1:0] row_data;
  logic             row_last;

  modport master (
    output row_valid,
    output row_data,
    output row_last,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_data,
    input  row_last,
    output row_ready
  );
endinterface

// File: rtl/omr_sheet_loader.sv
// rtl/omr_sheet_loader.sv - assembles key and student answer sheets for the OMR grader
module omr_sheet_loader #(
  parameter int NUM_Q = 10,
  parameter int OPT_W = 4,
  parameter int CNT_W = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   key_start,
  input  logic                   stu_start,
  omr_sheet_loader_if.slave      row_if,
  output logic [NUM_Q*OPT_W-1:0] correct_answers,
  output logic [NUM_Q*OPT_W-1:0] student_answers,
  output logic                   key_valid,
  output logic                   sheet_valid,
  output logic                   sheet_done,
  output logic [CNT_W-1:0]       blank_count,
  output logic [CNT_W-1:0]       multi_count,
  output logic                   frame_err,
  output logic                   key_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LOAD_KEY = 2'd1,
    LOAD_STU = 2'd2
  } state_t;

  state_t                 state;
  logic                   ready_q;
  logic [CNT_W-1:0]       row_cnt;
  logic [NUM_Q*OPT_W-1:0] shadow;
  logic [CNT_W-1:0]       blank_sh;
  logic [CNT_W-1:0]       multi_sh;
  logic                   key_bad;

  logic                   row_xfer;
  logic                   is_final;
  logic                   row_nz;
  logic                   row_single;
  logic                   row_blank;
  logic                   row_multi;
  logic [NUM_Q*OPT_W-1:0] shadow_nxt;
  logic [CNT_W-1:0]       blank_nxt;
  logic [CNT_W-1:0]       multi_nxt;
  logic                   key_bad_nxt;

  assign row_if.row_ready = ready_q;
  assign row_xfer = row_if.row_valid && ready_q;
  assign is_final = (row_cnt == CNT_W'(NUM_Q - 1));

  // Classify the incoming row and build the shadow contents as they will be once it is taken
  always_comb begin
    row_nz      = |row_if.row_data;
    row_single  = row_nz && ((row_if.row_data & (row_if.row_data - OPT_W'(1))) == '0);
    row_blank   = !row_nz;
    row_multi   = row_nz && !row_single;
    blank_nxt   = (row_blank && (blank_sh != '1)) ? blank_sh + CNT_W'(1) : blank_sh;
    multi_nxt   = (row_multi && (multi_sh != '1)) ? multi_sh + CNT_W'(1) : multi_sh;
    key_bad_nxt = key_bad || !row_single;
    shadow_nxt  = shadow;
    for (int q = 0; q < NUM_Q; q++) begin
      if (row_cnt == CNT_W'(q)) begin
        shadow_nxt[q*OPT_W +: OPT_W] = row_if.row_data;
      end
    end
  end

  // Sheet FSM: loads rows into the shadow, commits whole sheets, aborts badly framed or invalid ones
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      ready_q         <= 1'b0;
      row_cnt         <= '0;
      shadow          <= '0;
      blank_sh        <= '0;
      multi_sh        <= '0;
      key_bad         <= 1'b0;
      correct_answers <= '0;
      student_answers <= '0;
      key_valid       <= 1'b0;
      sheet_valid     <= 1'b0;
      sheet_done      <= 1'b0;
      blank_count     <= '0;
      multi_count     <= '0;
      frame_err       <= 1'b0;
      key_err         <= 1'b0;
    end else begin
      sheet_done <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          row_cnt  <= '0;
          shadow   <= '0;
          blank_sh <= '0;
          multi_sh <= '0;
          key_bad  <= 1'b0;
          if (key_start) begin
            state       <= LOAD_KEY;
            ready_q     <= 1'b1;
            sheet_valid <= 1'b0;
          end else if (stu_start && key_valid) begin
            state   <= LOAD_STU;
            ready_q <= 1'b1;
          end
        end
        LOAD_KEY, LOAD_STU: begin
          if (row_xfer) begin
            if (row_if.row_last != is_final) begin
              // Early row_last or missing row_last on the final slot: drop the sheet
              state     <= IDLE;
              ready_q   <= 1'b0;
              frame_err <= 1'b1;
              row_cnt   <= '0;
              shadow    <= '0;
            end else if (is_final) begin
              state   <= IDLE;
              ready_q <= 1'b0;
              row_cnt <= '0;
              shadow  <= '0;
              if (state == LOAD_KEY) begin
                if (key_bad_nxt) begin
                  key_valid <= 1'b0;
                  key_err   <= 1'b1;
                  frame_err <= 1'b1;
                end else begin
                  correct_answers <= shadow_nxt;
                  key_valid       <= 1'b1;
                  key_err         <= 1'b0;
                  sheet_valid     <= 1'b0;
                  sheet_done      <= 1'b1;
                end
              end else begin
                student_answers <= shadow_nxt;
                blank_count     <= blank_nxt;
                multi_count     <= multi_nxt;
                sheet_valid     <= 1'b1;
                sheet_done      <= 1'b1;
              end
            end else begin
              shadow   <= shadow_nxt;
              row_cnt  <= row_cnt + CNT_W'(1);
              blank_sh <= blank_nxt;
              multi_sh <= multi_nxt;
              key_bad  <= key_bad_nxt;
            end
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_omr_sheet_loader.sv
// tb/tb_omr_sheet_loader.sv - directed vector bench for omr_sheet_loader
module tb_omr_sheet_loader;

  localparam int NUM_Q = 10;
  localparam int OPT_W = 4;
  localparam int CNT_W = 4;

  logic                   clk;
  logic                   reset_n;
  logic                   key_start;
  logic                   stu_start;
  logic [NUM_Q*OPT_W-1:0] correct_answers;
  logic [NUM_Q*OPT_W-1:0] student_answers;
  logic                   key_valid;
  logic                   sheet_valid;
  logic                   sheet_done;
  logic [CNT_W-1:0]       blank_count;
  logic [CNT_W-1:0]       multi_count;
  logic                   frame_err;
  logic                   key_err;

  int checks = 0;
  int errors = 0;

  omr_sheet_loader_if #(.OPT_W(OPT_W)) row_if ();

  omr_sheet_loader #(.NUM_Q(NUM_Q), .OPT_W(OPT_W), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .key_start       (key_start),
    .stu_start       (stu_start),
    .row_if          (row_if.slave),
    .correct_answers (correct_answers),
    .student_answers (student_answers),
    .key_valid       (key_valid),
    .sheet_valid     (sheet_valid),
    .sheet_done      (sheet_done),
    .blank_count     (blank_count),
    .multi_count     (multi_count),
    .frame_err       (frame_err),
    .key_err         (key_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        is_key;
    logic [39:0] rows;
    int          nrows;
    int          last_pos;
    logic        exp_done;
    logic        exp_ferr;
    logic        exp_kv;
    logic        exp_kerr;
    logic        exp_sv;
    logic [39:0] exp_ca;
    logic [39:0] exp_sa;
    logic [3:0]  exp_bc;
    logic [3:0]  exp_mc;
  } vec_t;

  vec_t tbl [7];

  localparam logic [39:0] KEY1  = 40'h2184_2184_21;
  localparam logic [39:0] KEY3  = 40'h4218_4218_42;
  localparam logic [39:0] STU1  = 40'h2164_2104_21;
  localparam logic [39:0] BADK  = 40'h2184_2183_21;
  localparam logic [39:0] ALLF  = 40'hFF_FFFF_FFFF;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge right after the row was accepted
  task automatic xfer(input logic [3:0] data, input logic last);
    int n;
    n = 0;
    row_if.row_valid = 1'b1;
    row_if.row_data  = data;
    row_if.row_last  = last;
    while (row_if.row_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL xfer_timeout: got row_ready=%0b expected 1", row_if.row_ready);
    end
    @(negedge clk);
    row_if.row_valid = 1'b0;
    row_if.row_last  = 1'b0;
    row_if.row_data  = 4'h0;
  endtask

  task automatic send_sheet(input logic [39:0] rows, input int nrows, input int last_pos, input bit gaps);
    for (int i = 0; i < nrows; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
      xfer(rows[i*4 +: 4], (i == last_pos));
    end
  endtask

  task automatic pulse_start(input logic k, input logic s);
    key_start = k;
    stu_start = s;
    @(negedge clk);
    key_start = 1'b0;
    stu_start = 1'b0;
  endtask

  task automatic run_entry(input int i);
    pulse_start(tbl[i].is_key, !tbl[i].is_key);
    send_sheet(tbl[i].rows, tbl[i].nrows, tbl[i].last_pos, 1'b1);
    check($sformatf("v%0d sheet_done", i), sheet_done, tbl[i].exp_done);
    check($sformatf("v%0d frame_err", i), frame_err, tbl[i].exp_ferr);
    check($sformatf("v%0d key_valid", i), key_valid, tbl[i].exp_kv);
    check($sformatf("v%0d key_err", i), key_err, tbl[i].exp_kerr);
    check($sformatf("v%0d sheet_valid", i), sheet_valid, tbl[i].exp_sv);
    check($sformatf("v%0d correct_answers", i), correct_answers, tbl[i].exp_ca);
    check($sformatf("v%0d student_answers", i), student_answers, tbl[i].exp_sa);
    check($sformatf("v%0d blank_count", i), blank_count, tbl[i].exp_bc);
    check($sformatf("v%0d multi_count", i), multi_count, tbl[i].exp_mc);
    check($sformatf("v%0d row_ready_idle", i), row_if.row_ready, 1'b0);
    @(negedge clk);
    check($sformatf("v%0d done_pulse_end", i), sheet_done, 1'b0);
    check($sformatf("v%0d ferr_pulse_end", i), frame_err, 1'b0);
  endtask

  initial begin
    //            key   rows  n   last done ferr kv kerr sv ca    sa    bc     mc
    tbl[0] = '{1'b1, KEY1, 10,  9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, KEY1, 40'h0, 4'd0, 4'd0};
    tbl[1] = '{1'b0, STU1, 10,  9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, KEY1, STU1,  4'd1, 4'd1};
    tbl[2] = '{1'b0, KEY1,  6,  5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, KEY1, STU1,  4'd1, 4'd1};
    tbl[3] = '{1'b0, KEY1, 10, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, KEY1, STU1,  4'd1, 4'd1};
    tbl[4] = '{1'b0, 40'h0, 10, 9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, KEY1, 40'h0, 4'd10, 4'd0};
    tbl[5] = '{1'b0, ALLF, 10,  9, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, KEY1, ALLF,  4'd0, 4'd10};
    tbl[6] = '{1'b1, BADK, 10,  9, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, KEY1, ALLF,  4'd0, 4'd10};

    reset_n          = 1'b0;
    key_start        = 1'b0;
    stu_start        = 1'b0;
    row_if.row_valid = 1'b0;
    row_if.row_data  = 4'h0;
    row_if.row_last  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst row_ready", row_if.row_ready, 1'b0);
    check("rst correct_answers", correct_answers, 40'h0);
    check("rst student_answers", student_answers, 40'h0);
    check("rst key_valid", key_valid, 1'b0);
    check("rst sheet_valid", sheet_valid, 1'b0);
    check("rst key_err", key_err, 1'b0);
    reset_n = 1'b1;
    @(negedge clk);

    // stu_start without a key is ignored
    pulse_start(1'b0, 1'b1);
    check("nokey stu_start ignored", row_if.row_ready, 1'b0);

    for (int i = 0; i < 7; i++) run_entry(i);

    // After a rejected key, stu_start is ignored
    pulse_start(1'b0, 1'b1);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("badkey ready c%0d", c), row_if.row_ready, 1'b0);
      @(negedge clk);
    end

    // Reset in the middle of a student sheet
    pulse_start(1'b1, 1'b0);
    send_sheet(KEY1, 10, 9, 1'b0);
    check("mr key_valid", key_valid, 1'b1);
    pulse_start(1'b0, 1'b1);
    send_sheet(STU1, 4, -1, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    check("mr async row_ready", row_if.row_ready, 1'b0);
    check("mr async key_valid", key_valid, 1'b0);
    check("mr async correct_answers", correct_answers, 40'h0);
    check("mr async student_answers", student_answers, 40'h0);
    check("mr async blank_count", blank_count, 4'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    pulse_start(1'b1, 1'b0);
    send_sheet(KEY3, 10, 9, 1'b1);
    check("mr key3 done", sheet_done, 1'b1);
    check("mr key3 ca", correct_answers, KEY3);
    pulse_start(1'b0, 1'b1);
    send_sheet(STU1, 10, 9, 1'b1);
    check("mr stu sv", sheet_valid, 1'b1);
    check("mr stu sa", student_answers, STU1);
    check("mr stu bc", blank_count, 4'd1);
    check("mr stu mc", multi_count, 4'd1);

    // Simultaneous starts, key wins; extra pulses mid-load ignored
    pulse_start(1'b1, 1'b1);
    check("sim sheet_valid cleared", sheet_valid, 1'b0);
    check("sim key_valid held", key_valid, 1'b1);
    check("sim ready", row_if.row_ready, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) pulse_start(1'b1, 1'b1);
      if ($urandom_range(0, 1) == 0) @(negedge clk);
      xfer(KEY1[i*4 +: 4], (i == 9));
    end
    check("sim done", sheet_done, 1'b1);
    check("sim frame_err", frame_err, 1'b0);
    check("sim ca", correct_answers, KEY1);
    check("sim sv", sheet_valid, 1'b0);
    check("sim sa held", student_answers, STU1);
    @(negedge clk);
    check("sim done drop", sheet_done, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
